// File: rtl/mxv_pkg.sv
// Shared types and sizing helpers for the matrix-vector engine.
// - state_t        : engine control states
// - acc_length()   : result width needed for a MAX_N-term dot product
// - beats_per_row(): input beats needed to carry n columns over num_pe lanes
package mxv_pkg;

  typedef enum logic [1:0] {
    IDLE,
    LOAD_V,
    LOAD_M,
    DRAIN
  } state_t;

  function automatic int acc_length(input int word_length, input int max_n);
    return 2 * word_length + $clog2(max_n);
  endfunction

  function automatic int beats_per_row(input int n, input int num_pe);
    return (n + num_pe - 1) / num_pe;
  endfunction

endpackage

// File: rtl/mxv_result_fifo.sv
// Small synchronous FIFO holding finished result words.
// Ports:
//   clk, reset          : clock, asynchronous active-high reset
//   push, push_data     : write request and word (ignored while full)
//   pop, pop_data       : read request (ignored while empty), head word
//   full, empty         : occupancy flags
module mxv_result_fifo #(
  parameter int WIDTH = 21,
  parameter int DEPTH = 4
) (
  input  logic             clk,
  input  logic             reset,
  input  logic             push,
  input  logic [WIDTH-1:0] push_data,
  input  logic             pop,
  output logic [WIDTH-1:0] pop_data,
  output logic             full,
  output logic             empty
);

  localparam int AW = (DEPTH > 1) ? $clog2(DEPTH) : 1;
  localparam int CNTW = $clog2(DEPTH + 1);

  logic [WIDTH-1:0] mem_reg [DEPTH];
  logic [AW-1:0]    wr_ptr_reg;
  logic [AW-1:0]    rd_ptr_reg;
  logic [CNTW-1:0]  count_reg;
  logic             do_push;
  logic             do_pop;

  assign full     = (count_reg == CNTW'(DEPTH));
  assign empty    = (count_reg == '0);
  assign do_push  = push && !full;
  assign do_pop   = pop && !empty;
  assign pop_data = mem_reg[rd_ptr_reg];

  // Storage is cleared on reset so the head word reads as zero afterwards.
  for (genvar gi = 0; gi < DEPTH; gi++) begin : g_entry
    always_ff @(posedge clk or posedge reset) begin
      if (reset) begin
        mem_reg[gi] <= '0;
      end else if (do_push && (wr_ptr_reg == AW'(gi))) begin
        mem_reg[gi] <= push_data;
      end
    end
  end

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      wr_ptr_reg <= '0;
      rd_ptr_reg <= '0;
      count_reg  <= '0;
    end else begin
      if (do_push) begin
        wr_ptr_reg <= (wr_ptr_reg == AW'(DEPTH - 1)) ? '0 : wr_ptr_reg + 1'b1;
      end
      if (do_pop) begin
        rd_ptr_reg <= (rd_ptr_reg == AW'(DEPTH - 1)) ? '0 : rd_ptr_reg + 1'b1;
      end
      case ({do_push, do_pop})
        2'b10:   count_reg <= count_reg + 1'b1;
        2'b01:   count_reg <= count_reg - 1'b1;
        default: count_reg <= count_reg;
      endcase
    end
  end

endmodule

// File: rtl/mxv_engine.sv
// Matrix-vector multiply engine: y = M * v for an N x N matrix, 1 <= N <= MAX_N.
// Stream order: B = ceil(N/NUM_PE) vector beats, then N*B matrix beats row-major.
// Ports:
//   clk, reset                 : clock, asynchronous active-high reset
//   start, matrix_length       : begin request and N (sampled together in IDLE)
//   in_data/in_valid/in_ready  : operand stream, lane k = in_data[k*W +: W]
//   out_data/out_valid/out_ready/out_last : result stream, out_last marks y[N-1]
//   busy                       : engine not idle
//   done                       : pulse after the final result has been consumed
//   error                      : pulse after a start with illegal N
module mxv_engine
  import mxv_pkg::*;
#(
  parameter int WORD_LENGTH  = 8,
  parameter int NUM_PE       = 4,
  parameter int MAX_N        = 16,
  parameter int ACC_LENGTH   = acc_length(WORD_LENGTH, MAX_N),
  parameter int RESULT_DEPTH = 4
) (
  input  logic                          clk,
  input  logic                          reset,
  input  logic                          start,
  input  logic [WORD_LENGTH-1:0]        matrix_length,
  input  logic [NUM_PE*WORD_LENGTH-1:0] in_data,
  input  logic                          in_valid,
  output logic                          in_ready,
  output logic [ACC_LENGTH-1:0]         out_data,
  output logic                          out_valid,
  input  logic                          out_ready,
  output logic                          out_last,
  output logic                          busy,
  output logic                          done,
  output logic                          error
);

  localparam int MAX_BEATS = beats_per_row(MAX_N, NUM_PE);
  localparam int MAX_COLS  = MAX_BEATS * NUM_PE;
  localparam int CW = (MAX_COLS > 1) ? $clog2(MAX_COLS) : 1;
  localparam int NW = CW + 1;
  localparam int BW = (MAX_BEATS > 1) ? $clog2(MAX_BEATS) : 1;
  localparam int RW = (MAX_N > 1) ? $clog2(MAX_N) : 1;

  state_t                 state_reg, state_next;
  logic [NW-1:0]          n_reg;
  logic [BW-1:0]          beat_last_reg, beat_reg;
  logic [RW-1:0]          row_last_reg, row_reg;
  logic [ACC_LENGTH-1:0]  acc_reg;
  logic [ACC_LENGTH-1:0]  sum;
  logic                   done_reg, error_reg;
  logic [WORD_LENGTH-1:0] vec_mem [MAX_COLS];

  logic [CW-1:0]            col   [NUM_PE];
  logic [2*WORD_LENGTH-1:0] prod  [NUM_PE];

  logic                  n_legal, start_ok, accept, beat_end, row_end;
  logic                  fifo_full, fifo_empty, fifo_push, fifo_pop;
  logic [ACC_LENGTH:0]   push_data, pop_data;

  assign n_legal  = (matrix_length != '0) && (int'(matrix_length) <= MAX_N);
  assign start_ok = start && (state_reg == IDLE) && n_legal;
  // Stall on any full FIFO, not only before row-final beats, to keep the gate simple.
  assign in_ready = ((state_reg == LOAD_V) || (state_reg == LOAD_M)) && !fifo_full;
  assign accept   = in_valid && in_ready;
  assign beat_end = (beat_reg == beat_last_reg);
  assign row_end  = (row_reg == row_last_reg);

  // Lanes: column index per lane, columns beyond N contribute nothing.
  for (genvar gi = 0; gi < NUM_PE; gi++) begin : g_lane
    assign col[gi]  = CW'(int'(beat_reg) * NUM_PE + gi);
    assign prod[gi] = ({1'b0, col[gi]} < n_reg)
                    ? in_data[gi*WORD_LENGTH +: WORD_LENGTH] * vec_mem[col[gi]]
                    : '0;
  end

  // Adder tree over the lane products; wraps modulo 2^ACC_LENGTH.
  always_comb begin
    sum = '0;
    for (int k = 0; k < NUM_PE; k++) begin
      sum = sum + ACC_LENGTH'(prod[k]);
    end
  end

  // Vector store: entry j is only ever fed by lane j%NUM_PE on beat j/NUM_PE.
  for (genvar gi = 0; gi < MAX_COLS; gi++) begin : g_vec
    always_ff @(posedge clk or posedge reset) begin
      if (reset) begin
        vec_mem[gi] <= '0;
      end else if (accept && (state_reg == LOAD_V) && (beat_reg == BW'(gi / NUM_PE))
                   && (NW'(gi) < n_reg)) begin
        vec_mem[gi] <= in_data[(gi % NUM_PE)*WORD_LENGTH +: WORD_LENGTH];
      end
    end
  end

  always_comb begin
    state_next = state_reg;
    case (state_reg)
      IDLE:    if (start_ok) state_next = LOAD_V;
      LOAD_V:  if (accept && beat_end) state_next = LOAD_M;
      LOAD_M:  if (accept && beat_end && row_end) state_next = DRAIN;
      // The entry tagged last is always the final one, so popping it empties the FIFO.
      DRAIN:   if (fifo_pop && pop_data[ACC_LENGTH]) state_next = IDLE;
      default: state_next = IDLE;
    endcase
  end

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      state_reg     <= IDLE;
      n_reg         <= '0;
      beat_last_reg <= '0;
      row_last_reg  <= '0;
      beat_reg      <= '0;
      row_reg       <= '0;
      acc_reg       <= '0;
      done_reg      <= 1'b0;
      error_reg     <= 1'b0;
    end else begin
      state_reg <= state_next;
      done_reg  <= (state_reg == DRAIN) && (state_next == IDLE);
      error_reg <= start && (state_reg == IDLE) && !n_legal;
      if (start_ok) begin
        n_reg         <= NW'(matrix_length);
        beat_last_reg <= BW'(beats_per_row(int'(matrix_length), NUM_PE) - 1);
        row_last_reg  <= RW'(int'(matrix_length) - 1);
        beat_reg      <= '0;
        row_reg       <= '0;
        acc_reg       <= '0;
      end else if (accept) begin
        beat_reg <= beat_end ? '0 : beat_reg + 1'b1;
        if (state_reg == LOAD_M) begin
          acc_reg <= beat_end ? '0 : acc_reg + sum;
          if (beat_end) begin
            row_reg <= row_end ? '0 : row_reg + 1'b1;
          end
        end
      end
    end
  end

  assign fifo_push = accept && (state_reg == LOAD_M) && beat_end;
  assign push_data = {row_end, acc_reg + sum};
  assign fifo_pop  = out_valid && out_ready;

  mxv_result_fifo #(
    .WIDTH (ACC_LENGTH + 1),
    .DEPTH (RESULT_DEPTH)
  ) u_fifo (
    .clk       (clk),
    .reset     (reset),
    .push      (fifo_push),
    .push_data (push_data),
    .pop       (fifo_pop),
    .pop_data  (pop_data),
    .full      (fifo_full),
    .empty     (fifo_empty)
  );

  assign out_valid = !fifo_empty;
  assign out_data  = pop_data[ACC_LENGTH-1:0];
  assign out_last  = pop_data[ACC_LENGTH];
  assign busy      = (state_reg != IDLE);
  assign done      = done_reg;
  assign error     = error_reg;

endmodule
